// File: rtl/lcd_bus_pkg.sv
// Shared types, default timing and the power-up command table for the
// HD44780-style LCD write-bus controller.
package lcd_bus_pkg;

   localparam int unsigned T_PWRUP_DEF = 1_000_000;
   localparam int unsigned T_SETUP_DEF = 4;
   localparam int unsigned T_EHIGH_DEF = 25;
   localparam int unsigned T_CMD_DEF   = 2_500;
   localparam int unsigned T_LONG_DEF  = 82_000;

   localparam int unsigned NumInit = 5;

   typedef enum logic [2:0] {
      StPwrup,
      StInitIssue,
      StIdle,
      StSetup,
      StEhigh,
      StWait
   } lcd_state_e;

   // 8-bit bus/2 lines, display off, clear, entry mode, display on.
   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      logic [7:0] cmd;
      case (idx)
         3'd0:    cmd = 8'h38;
         3'd1:    cmd = 8'h08;
         3'd2:    cmd = 8'h01;
         3'd3:    cmd = 8'h06;
         3'd4:    cmd = 8'h0C;
         default: cmd = 8'h00;
      endcase
      return cmd;
   endfunction

   // Clear and home commands need the long post-pulse wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant: the requester not served last wins a tie.
module lcd_rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   input  logic xfer,
   output logic grant,
   output logic last_next
);

   always_comb begin
      grant = ~last;
      if (valid0 && valid1) begin
         grant = ~last;
      end else if (valid1) begin
         grant = 1'b1;
      end else if (valid0) begin
         grant = 1'b0;
      end
      last_next = xfer ? grant : last;
   end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// LCD write-bus controller: power-up wait, fixed init sequence, then
// round-robin arbitrated byte writes from two requesters.
module lcd_bus_ctrl
   import lcd_bus_pkg::*;
#(
   parameter int unsigned T_PWRUP = T_PWRUP_DEF,
   parameter int unsigned T_SETUP = T_SETUP_DEF,
   parameter int unsigned T_EHIGH = T_EHIGH_DEF,
   parameter int unsigned T_CMD   = T_CMD_DEF,
   parameter int unsigned T_LONG  = T_LONG_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ0_VALID,
   input  logic       REQ0_RS,
   input  logic [7:0] REQ0_DATA,
   output logic       REQ0_READY,
   input  logic       REQ1_VALID,
   input  logic       REQ1_RS,
   input  logic [7:0] REQ1_DATA,
   output logic       REQ1_READY,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic [7:0] LCD_DATA,
   output logic       BUSY,
   output logic       INIT_DONE
);

   localparam int unsigned TMax = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
   localparam int unsigned TW   = $clog2(TMax + 1);

   lcd_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic          init_done_q, init_done_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          busy_q;
   logic          last_q, last_d;
   logic          grant;
   logic          can_accept;
   logic          xfer;
   logic [TW-1:0] wait_last;

   lcd_rr_arb2 u_arb (
      .valid0    (REQ0_VALID),
      .valid1    (REQ1_VALID),
      .last      (last_q),
      .xfer      (xfer),
      .grant     (grant),
      .last_next (last_d)
   );

   assign can_accept = (state_q == StIdle) && init_done_q;
   assign REQ0_READY = can_accept && !grant;
   assign REQ1_READY = can_accept && grant;
   assign xfer       = (REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY);

   assign wait_last = is_long_cmd(rs_q, data_q) ? TW'(T_LONG - 1) : TW'(T_CMD - 1);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      data_d      = data_q;
      unique case (state_q)
         StPwrup: begin
            if (timer_q == TW'(T_PWRUP - 1)) state_d = StInitIssue;
            else timer_d = timer_q + 1'b1;
         end
         StInitIssue: begin
            state_d = StSetup;
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q);
         end
         StIdle: begin
            if (xfer) begin
               state_d = StSetup;
               rs_d    = grant ? REQ1_RS : REQ0_RS;
               data_d  = grant ? REQ1_DATA : REQ0_DATA;
            end
         end
         StSetup: begin
            if (timer_q == TW'(T_SETUP - 1)) state_d = StEhigh;
            else timer_d = timer_q + 1'b1;
         end
         StEhigh: begin
            if (timer_q == TW'(T_EHIGH - 1)) state_d = StWait;
            else timer_d = timer_q + 1'b1;
         end
         StWait: begin
            if (timer_q == wait_last) begin
               if (init_done_q) begin
                  state_d = StIdle;
               end else if (idx_q == 3'(NumInit - 1)) begin
                  state_d     = StIdle;
                  init_done_d = 1'b1;
               end else begin
                  // Chain straight into the next init command.
                  state_d = StSetup;
                  idx_d   = idx_q + 3'd1;
                  rs_d    = 1'b0;
                  data_d  = init_cmd(idx_q + 3'd1);
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StPwrup;
      endcase
      if (state_d != state_q) timer_d = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StPwrup;
         timer_q     <= '0;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         last_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         busy_q      <= (state_d != StIdle);
         last_q      <= last_d;
      end
   end

   // E follows the state register directly so reset drops it asynchronously.
   assign LCD_E     = (state_q == StEhigh);
   assign LCD_RS    = rs_q;
   assign LCD_DATA  = data_q;
   assign BUSY      = busy_q;
   assign INIT_DONE = init_done_q;

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 SHALL have parameter T_PWRUP, default 1_000_000, power-up wait in CLK cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter T_SETUP, default 4, cycles from RS/DATA change to LCD_E rise.
REQ-003 SHALL have parameter T_EHIGH, default 25, cycles LCD_E stays high.
REQ-004 SHALL have parameter T_CMD, default 2_500, post-pulse wait for normal writes (50 us).
REQ-005 SHALL have parameter T_LONG, default 82_000, post-pulse wait for clear/home (1.64 ms).
REQ-006 SHALL have port CLK, input, 1, sole clock; one clock domain only.
REQ-007 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have ports REQ0_VALID and REQ1_VALID, input, 1, requester n has a byte pending.
REQ-009 SHALL have ports REQ0_RS and REQ1_RS, input, 1, 0 = command, 1 = data.
REQ-010 SHALL have ports REQ0_DATA and REQ1_DATA, input, 8, byte to write.
REQ-011 SHALL have ports REQ0_READY and REQ1_READY, output, 1, byte accepted this cycle when VALID is also high.
REQ-012 SHALL have ports LCD_E, LCD_RS, LCD_DATA, output, 1/1/8, HD44780-style write bus.
REQ-013 SHALL have ports BUSY and INIT_DONE, output, 1 each, status.

Function
REQ-014 FSM states SHALL be PWRUP, INIT_ISSUE, IDLE, SETUP, EHIGH, WAIT.
REQ-015 PWRUP SHALL last exactly T_PWRUP cycles, then go to INIT_ISSUE.
REQ-016 Init SHALL issue 0x38, 0x08, 0x01, 0x06, 0x0C in that order, all with RS=0.
REQ-017 Each init command SHALL use the SETUP/EHIGH/WAIT path, with no IDLE cycle between commands.
REQ-018 A write SHALL occupy T_SETUP cycles in SETUP with LCD_E=0, then T_EHIGH cycles in EHIGH with LCD_E=1, then WAIT with LCD_E=0.
REQ-019 WAIT SHALL last T_LONG cycles when RS=0 and DATA is 0x01, 0x02 or 0x03.
REQ-020 WAIT SHALL last T_CMD cycles in every other case.
REQ-021 LCD_RS and LCD_DATA SHALL load on the transfer edge and hold stable until the next transfer.
REQ-022 INIT_DONE SHALL rise on entry to IDLE after the 5th init command's WAIT, and stay high until reset.
REQ-023 READY SHALL be high only in IDLE with INIT_DONE=1, and only for the granted requester; the other READY is low.
REQ-024 Transfer SHALL occur when VALID&&READY; next state is SETUP.
REQ-025 A single requester's back-to-back writes SHALL be separated by exactly one IDLE cycle.
REQ-026 Arbitration SHALL be 2-way round-robin: with both VALID, grant the requester not served last.
REQ-027 With one VALID, that requester SHALL be granted; the last-served pointer updates only on transfer.
REQ-028 VALID dropping before READY SHALL be legal; no transfer occurs and no state changes.
REQ-029 VALID during PWRUP or init SHALL be held off with READY=0; nothing is dropped.
REQ-030 BUSY SHALL equal (state != IDLE).
REQ-031 Timer width SHALL be clog2(max(T_PWRUP, T_LONG)+1); the timer resets on every state change and never wraps.

Reset
REQ-032 RST high SHALL asynchronously force the following: state PWRUP, timers 0, init index 0.
REQ-033 RST high SHALL also clear all outputs: LCD_E, LCD_RS, LCD_DATA, READYs, BUSY, INIT_DONE all 0.
REQ-034 RST high SHALL set the last-served pointer to 1, so REQ0 wins first.
REQ-035 Reset mid-write SHALL drop LCD_E immediately, discard the in-flight byte and restart the full power-up/init sequence.

Structure
REQ-036 Package lcd_bus_pkg SHALL hold the state enum, the 5-entry init command table and the default timing constants.
REQ-037 The round-robin grant SHALL be a sub-module lcd_rr_arb2 (inputs: two valids, last pointer, transfer strobe; output: grant).

Verification
Bench parameters: T_PWRUP=100, T_SETUP=2, T_EHIGH=3, T_CMD=10, T_LONG=40. Cycle 0 = first CLK edge after RST falls.
REQ-038 Release reset, no requests -> LCD_E pulses 5 times with DATA 38,08,01,06,0C, RS=0, each pulse 3 cycles wide; INIT_DONE rises at cycle 205.
REQ-039 After init, REQ0 sends RS=1 DATA=0x41 -> READY0 high 1 cycle, LCD_E high 3 cycles starting 2 cycles after transfer, BUSY high 15 cycles.
REQ-040 Both VALID continuously, REQ0=0x41, REQ1=0x42 -> bytes alternate 41,42,41,42, REQ0 first, one IDLE cycle between writes.
REQ-041 REQ1 sends RS=0 DATA=0x01 -> WAIT 40 cycles, BUSY high 45 cycles; RS=1 DATA=0x01 -> BUSY high 15 cycles.
REQ-042 Assert RST during EHIGH of a user write -> LCD_E=0 immediately; INIT_DONE=0; full init replays, INIT_DONE at cycle 205.
REQ-043 REQ0_VALID asserted at cycle 50 and held -> READY0 stays 0 until cycle 205, then the transfer occurs on the first IDLE cycle.
